lock_code_programmer: RTL and testbench
=======================================

Name: lock_code_programmer

Overview:
Writer side of the combination-lock datapath. The lock checker FSM reads the stored combination. This block lets the user program a new DIGITS-long combination from the switches and the ENTER pushbutton, with a confirm pass (enter twice). It holds the committed code and exposes a per-digit read port that the checker's MATCH comparator uses.

Parameters:
DIGITS, 4, number of digits in the combination (2..8)
DW, 4, width of one digit in bits
DEFAULT_CODE, 16'h1234, reset value of the code; digit i = DEFAULT_CODE[i*DW +: DW]; digit 0 is entered first

Ports:
clk  in  1  system clock (MAX10_CLK1_50 at top level)
RESETN  in  1  synchronous active-low reset, sampled on rising clk
PROG  in  1  programming-mode request (slide switch, level)
ENTER  in  1  raw pushbutton, active-low (KEY), asynchronous to clk
DIN  in  DW  digit value from switches
rd_idx  in  $clog2(DIGITS)  checker read index
rd_digit  out  DW  committed digit at rd_idx (combinational from code register); 0 if rd_idx >= DIGITS
busy  out  1  high in ENTRY, CONFIRM, COMMIT, ERR; checker must ignore MATCH while busy
idx  out  $clog2(DIGITS)  current digit position (LED display)
state  out  3  IDLE=0, ENTRY=1, CONFIRM=2, COMMIT=3, ERR=4, HOLD=5
committed  out  1  one-cycle pulse when a new code is written
error  out  1  one-cycle pulse on confirm mismatch

Behaviour:
- Reset (RESETN=0 at posedge): state=IDLE, idx=0, code=DEFAULT_CODE, shadow=0, mismatch flag=0, committed=0, error=0, sync flops=1. Reset mid-programming discards the shadow and restores DEFAULT_CODE.
- ENTER conditioning: 2-flop synchronizer (s1, s2) plus history flop s3. press = s3 & ~s2, one cycle wide. A press is seen 2-3 clocks after ENTER falls. Holding the button low gives exactly one press.
- DIN is sampled in the press cycle.
- IDLE: PROG=1 -> ENTRY with idx=0. Presses are ignored.
- ENTRY: each press writes shadow[idx]=DIN and increments idx. A press at idx=DIGITS-1 -> CONFIRM with idx=0 and the mismatch flag cleared.
- CONFIRM: each press compares DIN to shadow[idx] and sets the sticky mismatch flag on inequality. Entry always continues through all DIGITS digits, so the position of a mismatch is never revealed. A press at the last digit -> ERR if mismatch (including the last digit) else COMMIT.
- COMMIT: one cycle. code <= shadow, committed=1 -> HOLD.
- ERR: one cycle. error=1, code unchanged -> HOLD.
- HOLD: waits for PROG=0 -> IDLE. This prevents immediate re-entry.
- Abort: PROG=0 while in ENTRY or CONFIRM -> IDLE next cycle. Shadow is discarded, no pulse. Abort takes priority over a simultaneous press.
- idx wraps only by state transition, never by overflow. idx=0 in IDLE and HOLD.
- rd_digit reflects a new code the cycle after COMMIT.

Optional Feature:
PROG_LOCKOUT_EN:
- Defined: a 2-bit counter counts consecutive ERR outcomes and is cleared by COMMIT or reset. On the third ERR the FSM enters LOCKED (state=6) instead of HOLD. LOCKED ignores PROG and ENTER until RESETN, with busy=0 and error held high.
- Undefined: no counter and no LOCKED state; ERR always goes to HOLD.

Test Plan:
1. Reset, rd_idx=0..3 -> rd_digit=4,3,2,1; state=0; busy=0.
2. PROG=1; enter 5,6,7,8 then 5,6,7,8 -> committed pulse of exactly 1 cycle; state sequence 1->2->3->5. After PROG=0, state=0 and rd_digit(0..3)=5,6,7,8.
3. Enter 9,9,9,9 then 9,9,0,9 -> error pulse after the 4th confirm press, not after the 3rd; code remains 4,3,2,1.
4. Abort: PROG=1, two presses, PROG=0 simultaneous with a press -> state=0 next cycle, no pulse, code unchanged. Hold ENTER low for 100 cycles -> only one digit is accepted.
5. Reset asserted during CONFIRM after a prior commit of 5678 -> state=0 and code=4,3,2,1.
6. With PROG_LOCKOUT_EN: three failed confirms -> state=6, error stuck at 1, PROG/ENTER ignored; reset recovers.

Source files
------------

// File: rtl/lock_code_programmer_if.sv
// Switch/button inputs and checker-facing outputs of the code programmer.
// slave = programmer side, master = board/checker side.
interface lock_code_programmer_if #(
    parameter int DIGITS = 4,
    parameter int DW     = 4
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic          PROG;
    logic          ENTER;
    logic [DW-1:0] DIN;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_digit;
    logic          busy;
    logic [IW-1:0] idx;
    logic [2:0]    state;
    logic          committed;
    logic          error;

    modport slave (
        input  PROG, ENTER, DIN, rd_idx,
        output rd_digit, busy, idx, state, committed, error
    );

    modport master (
        output PROG, ENTER, DIN, rd_idx,
        input  rd_digit, busy, idx, state, committed, error
    );
endinterface

// File: rtl/lock_code_programmer.sv
// Programs a new lock combination with a confirm pass and serves reads.
// Optional macro PROG_LOCKOUT_EN: three consecutive failed confirms lock out.
module lock_code_programmer #(
    parameter int                     DIGITS       = 4,
    parameter int                     DW           = 4,
    parameter logic [DIGITS*DW-1:0]   DEFAULT_CODE = 'h1234
) (
    input  logic                  clk,
    input  logic                  RESETN,
    lock_code_programmer_if.slave bus
);
    localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        CONFIRM = 3'd2,
        COMMIT  = 3'd3,
        ERR     = 3'd4,
        HOLD    = 3'd5
`ifdef PROG_LOCKOUT_EN
        , LOCKED = 3'd6
`endif
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [DIGITS*DW-1:0]  r_code;
    logic [DIGITS*DW-1:0]  r_shadow;
    logic                  r_mism;
    logic                  r_s1;
    logic                  r_s2;
    logic                  r_s3;

    state_t                w_nstate;
    logic [IW-1:0]         w_nidx;
    logic                  w_press;
    logic                  w_neq;
    logic                  w_sh_we;
    logic                  w_code_we;
    logic                  w_mism_clr;
    logic                  w_mism_set;
    logic [DW-1:0]         w_sh_digit;

    assign w_press    = r_s3 & ~r_s2;
    assign w_sh_digit = r_shadow[int'(r_idx)*DW +: DW];
    assign w_neq      = (bus.DIN != w_sh_digit);

`ifdef PROG_LOCKOUT_EN
    logic [1:0] r_errcnt;

    // Count consecutive failed confirms; a good commit forgives them
    always_ff @(posedge clk) begin
        if (!RESETN)
            r_errcnt <= '0;
        else if (r_state == COMMIT)
            r_errcnt <= '0;
        else if (r_state == ERR && r_errcnt != 2'd3)
            r_errcnt <= r_errcnt + 2'd1;
    end
`endif

    // Next state, digit position and datapath write strobes
    always_comb begin
        w_nstate   = r_state;
        w_nidx     = r_idx;
        w_sh_we    = 1'b0;
        w_code_we  = 1'b0;
        w_mism_clr = 1'b0;
        w_mism_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.PROG) begin
                    w_nstate = ENTRY;
                    w_nidx   = '0;
                end
            end
            ENTRY: begin
                if (!bus.PROG) begin
                    w_nstate = IDLE;
                    w_nidx   = '0;
                end else if (w_press) begin
                    w_sh_we = 1'b1;
                    if (r_idx == LAST) begin
                        w_nstate   = CONFIRM;
                        w_nidx     = '0;
                        w_mism_clr = 1'b1;
                    end else begin
                        w_nidx = r_idx + 1'b1;
                    end
                end
            end
            CONFIRM: begin
                if (!bus.PROG) begin
                    w_nstate = IDLE;
                    w_nidx   = '0;
                end else if (w_press) begin
                    w_mism_set = w_neq;
                    if (r_idx == LAST) begin
                        w_nidx   = '0;
                        w_nstate = (r_mism | w_neq) ? ERR : COMMIT;
                    end else begin
                        w_nidx = r_idx + 1'b1;
                    end
                end
            end
            COMMIT: begin
                w_code_we = 1'b1;
                w_nstate  = HOLD;
            end
            ERR: begin
`ifdef PROG_LOCKOUT_EN
                w_nstate = (r_errcnt == 2'd2) ? LOCKED : HOLD;
`else
                w_nstate = HOLD;
`endif
            end
            HOLD: begin
                if (!bus.PROG)
                    w_nstate = IDLE;
            end
`ifdef PROG_LOCKOUT_EN
            LOCKED: begin
                w_nstate = LOCKED;
            end
`endif
            default: begin
                w_nstate = IDLE;
                w_nidx   = '0;
            end
        endcase
    end

    // Button synchronizer, FSM registers, shadow and committed code
    always_ff @(posedge clk) begin
        if (!RESETN) begin
            r_s1     <= 1'b1;
            r_s2     <= 1'b1;
            r_s3     <= 1'b1;
            r_state  <= IDLE;
            r_idx    <= '0;
            r_code   <= DEFAULT_CODE;
            r_shadow <= '0;
            r_mism   <= 1'b0;
        end else begin
            r_s1    <= bus.ENTER;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= w_nstate;
            r_idx   <= w_nidx;
            if (w_sh_we)
                r_shadow[int'(r_idx)*DW +: DW] <= bus.DIN;
            if (w_mism_clr)
                r_mism <= 1'b0;
            else if (w_mism_set)
                r_mism <= 1'b1;
            if (w_code_we)
                r_code <= r_shadow;
        end
    end

    // Checker read port, zero for positions beyond the code length
    always_comb begin
        bus.rd_digit = '0;
        if (int'(bus.rd_idx) < DIGITS)
            bus.rd_digit = r_code[int'(bus.rd_idx)*DW +: DW];
    end

    assign bus.state     = r_state;
    assign bus.idx       = r_idx;
    assign bus.busy      = (r_state == ENTRY) || (r_state == CONFIRM) ||
                           (r_state == COMMIT) || (r_state == ERR);
    assign bus.committed = (r_state == COMMIT);
`ifdef PROG_LOCKOUT_EN
    assign bus.error     = (r_state == ERR) || (r_state == LOCKED);
`else
    assign bus.error     = (r_state == ERR);
`endif
endmodule

// File: tb/tb_lock_code_programmer.sv
// Randomized bench for lock_code_programmer with a transaction-level model
// compared every cycle, plus literal checks of the main scenarios.
module tb_lock_code_programmer;
    localparam int DIGITS = 4;
    localparam int DW     = 4;
    localparam int DCODE  = 'h1234;

    logic clk = 1'b0;
    logic RESETN = 1'b0;
    always #5 clk = ~clk;

    lock_code_programmer_if #(.DIGITS(DIGITS), .DW(DW)) bus ();

    lock_code_programmer #(
        .DIGITS(DIGITS), .DW(DW), .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk), .RESETN(RESETN), .bus(bus)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int m_state, m_idx, m_errs;
    int m_code[DIGITS];
    int m_sh[DIGITS];
    bit m_mism, h1, h2, h3;
    bit mdl_on = 0;

    task automatic model_step();
        bit press;
        if (!RESETN) begin
            m_state = 0; m_idx = 0; m_mism = 0; m_errs = 0;
            for (int i = 0; i < DIGITS; i++) begin
                m_code[i] = (DCODE >> (i * DW)) % (1 << DW);
                m_sh[i] = 0;
            end
            h1 = 1; h2 = 1; h3 = 1;
            mdl_on = 1;
            return;
        end
        if (!mdl_on) return;
        press = h3 && !h2;
        h3 = h2; h2 = h1; h1 = bus.ENTER;
        case (m_state)
            0: if (bus.PROG) begin m_state = 1; m_idx = 0; end
            1, 2: begin
                if (!bus.PROG) begin
                    m_state = 0; m_idx = 0;
                end else if (press) begin
                    if (m_state == 1) m_sh[m_idx] = int'(bus.DIN);
                    else if (m_sh[m_idx] != int'(bus.DIN)) m_mism = 1;
                    if (m_idx < DIGITS - 1) m_idx++;
                    else begin
                        m_idx = 0;
                        if (m_state == 1) begin m_state = 2; m_mism = 0; end
                        else m_state = m_mism ? 4 : 3;
                    end
                end
            end
            3: begin m_code = m_sh; m_state = 5; m_errs = 0; end
            4: begin
                m_errs++;
`ifdef PROG_LOCKOUT_EN
                m_state = (m_errs >= 3) ? 6 : 5;
`else
                m_state = 5;
`endif
            end
            5: if (!bus.PROG) m_state = 0;
            default: ;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle comparison ----------------
    int c_commit = 0;
    int c_err = 0;
    int seq[$];
    int last_st = 0;

    initial forever begin
        @(negedge clk);
        if (mdl_on) begin
            int e_rd;
            e_rd = (int'(bus.rd_idx) < DIGITS) ? m_code[bus.rd_idx] : 0;
            chk("state", int'(bus.state), m_state);
            chk("idx", int'(bus.idx), m_idx);
            chk("busy", int'(bus.busy), int'(m_state >= 1 && m_state <= 4));
            chk("committed", int'(bus.committed), int'(m_state == 3));
            chk("error", int'(bus.error), int'(m_state == 4 || m_state == 6));
            chk("rd_digit", int'(bus.rd_digit), e_rd);
            c_commit += int'(bus.committed);
            c_err += int'(bus.error);
            if (int'(bus.state) != last_st) begin
                seq.push_back(int'(bus.state));
                last_st = int'(bus.state);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit pin = 0;

    task automatic tick();
        @(posedge clk);
        #2;
        if (!pin) bus.rd_idx = 2'($urandom_range(0, DIGITS - 1));
    endtask

    task automatic press(int d);
        bus.DIN = DW'(d);
        bus.ENTER = 1'b0;
        repeat ($urandom_range(3, 8)) tick();
        bus.ENTER = 1'b1;
        bus.DIN = DW'($urandom);
        repeat ($urandom_range(4, 6)) tick();
    endtask

    task automatic chk_code(string nm, int e0, int e1, int e2, int e3);
        int e[DIGITS];
        e = '{e0, e1, e2, e3};
        pin = 1;
        for (int i = 0; i < DIGITS; i++) begin
            bus.rd_idx = 2'(i);
            #1;
            chk(nm, int'(bus.rd_digit), e[i]);
        end
        pin = 0;
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        bus.PROG = 1'b0;
        bus.ENTER = 1'b1;
        repeat (2) tick();
        RESETN = 1'b1;
        repeat (2) tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.PROG = 1'b0;
        bus.ENTER = 1'b1;
        bus.DIN = '0;
        bus.rd_idx = '0;
        do_reset();

        // reset state
        chk_code("reset_code", 4, 3, 2, 1);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_busy", int'(bus.busy), 0);

        // program 5678 with matching confirm
        c_commit = 0;
        seq.delete();
        bus.PROG = 1'b1;
        tick();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < DIGITS; i++) press(5 + i);
        repeat (3) tick();
        chk("commit_pulse", c_commit, 1);
        chk("hold_state", int'(bus.state), 5);
        chk("seq_len", seq.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("seq", (i < seq.size()) ? seq[i] : -1, (i < 3) ? i + 1 : 5);
        bus.PROG = 1'b0;
        repeat (2) tick();
        chk("idle_after", int'(bus.state), 0);
        chk_code("new_code", 5, 6, 7, 8);

        // confirm mismatch on third digit
        do_reset();
        c_err = 0;
        bus.PROG = 1'b1;
        tick();
        for (int i = 0; i < DIGITS; i++) press(9);
        press(9); press(9); press(0);
        chk("no_err_early", c_err, 0);
        press(9);
        chk("err_pulse", c_err, 1);
        chk_code("code_kept", 4, 3, 2, 1);
        bus.PROG = 1'b0;
        repeat (3) tick();

        // abort coinciding with a press
        c_commit = 0; c_err = 0;
        bus.PROG = 1'b1;
        tick();
        press(1); press(2);
        bus.DIN = 4'd3;
        bus.ENTER = 1'b0;
        tick(); tick();
        bus.PROG = 1'b0;
        tick();
        chk("abort_state", int'(bus.state), 0);
        bus.ENTER = 1'b1;
        repeat (5) tick();
        chk("abort_no_commit", c_commit, 0);
        chk("abort_no_err", c_err, 0);
        chk_code("abort_code", 4, 3, 2, 1);

        // long button hold yields one digit
        bus.PROG = 1'b1;
        repeat (3) tick();
        bus.DIN = 4'd7;
        bus.ENTER = 1'b0;
        repeat (100) tick();
        chk("hold_one_digit", int'(bus.idx), 1);
        bus.ENTER = 1'b1;
        repeat (4) tick();
        bus.PROG = 1'b0;
        repeat (2) tick();

        // reset in CONFIRM after a prior commit
        bus.PROG = 1'b1;
        tick();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < DIGITS; i++) press(5 + i);
        bus.PROG = 1'b0;
        repeat (2) tick();
        bus.PROG = 1'b1;
        tick();
        for (int i = 0; i < DIGITS; i++) press(5 + i);
        press(5); press(6);
        chk("in_confirm", int'(bus.state), 2);
        RESETN = 1'b0;
        bus.PROG = 1'b0;
        tick();
        chk("reset_mid_state", int'(bus.state), 0);
        RESETN = 1'b1;
        tick();
        chk_code("reset_mid_code", 4, 3, 2, 1);

`ifdef PROG_LOCKOUT_EN
        for (int r = 0; r < 3; r++) begin
            bus.PROG = 1'b1;
            tick();
            for (int i = 0; i < DIGITS; i++) press(1);
            for (int i = 0; i < DIGITS; i++) press(2);
            bus.PROG = 1'b0;
            repeat (3) tick();
        end
        chk("locked_state", int'(bus.state), 6);
        bus.PROG = 1'b1;
        press(3);
        chk("locked_stays", int'(bus.state), 6);
        chk("locked_error", int'(bus.error), 1);
        chk("locked_busy", int'(bus.busy), 0);
        do_reset();
        chk("unlock_state", int'(bus.state), 0);
`endif

        // randomized sessions
        for (int s = 0; s < 40; s++) begin
            int d[2*DIGITS];
            int n;
            for (int i = 0; i < DIGITS; i++) begin
                d[i] = int'($urandom_range(0, 15));
                d[i + DIGITS] = d[i];
            end
            if ($urandom_range(0, 2) == 0)
                d[DIGITS + $urandom_range(0, DIGITS - 1)] ^= int'($urandom_range(1, 15));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2*DIGITS - 1))
                                            : 2*DIGITS;
            bus.PROG = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            for (int i = 0; i < n; i++) press(d[i]);
            if ($urandom_range(0, 9) == 0) do_reset();
            repeat ($urandom_range(1, 4)) tick();
            bus.PROG = 1'b0;
            repeat ($urandom_range(2, 5)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
